// File: rtl/pulse_train_gen_pkg.sv
`default_nettype none
// ============================================================================
// pulse_train_gen_pkg : shared FSM encoding and timer sizing helper
// Rev 1.0
// ============================================================================
package pulse_train_gen_pkg;

  localparam int C_STATE_W = 2;

  localparam logic [C_STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [C_STATE_W-1:0] ST_HIGH = 2'd1;
  localparam logic [C_STATE_W-1:0] ST_LOW  = 2'd2;
  localparam logic [C_STATE_W-1:0] ST_DONE = 2'd3;

  // One spare bit so a phase length that is an exact power of two still fits.
  function automatic int timer_width(input int high_cyc, input int low_cyc);
    return $clog2((high_cyc > low_cyc) ? high_cyc : low_cyc) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_train_gen_phase_timer.sv
`default_nettype none
// ============================================================================
// pulse_train_gen_phase_timer : loadable down-counter that saturates at zero
// Rev 1.0
// ============================================================================
module pulse_train_gen_phase_timer #(
  parameter int TIMER_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_value,
  output logic               zero
);

  logic [TIMER_W-1:0] value_q;
  logic [TIMER_W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (value_q != '0) begin
      value_d = value_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign zero = (value_q == '0);

endmodule
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// pulse_train_gen : emits bursts of fixed-width pulses under start/busy/done
// Rev 1.0
// ============================================================================
module pulse_train_gen
  import pulse_train_gen_pkg::*;
#(
  parameter int CNT_W    = 3,
  parameter int HIGH_CYC = 2,
  parameter int LOW_CYC  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count_in,
  input  logic             abort,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  localparam int TIMER_W = timer_width(HIGH_CYC, LOW_CYC);
  localparam logic [TIMER_W-1:0] C_HIGH_LOAD = TIMER_W'(HIGH_CYC - 1);
  localparam logic [TIMER_W-1:0] C_LOW_LOAD  = TIMER_W'(LOW_CYC - 1);

  if (HIGH_CYC < 1 || LOW_CYC < 1) begin : g_bad_params
    $error("pulse_train_gen: HIGH_CYC and LOW_CYC must both be >= 1");
  end

  logic [C_STATE_W-1:0] state_q, state_d;
  logic                 pulse_out_q, pulse_out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     remaining_q, remaining_d;

  logic                 w_tmr_load;
  logic [TIMER_W-1:0]   w_tmr_load_value;
  logic                 w_tmr_zero;

  pulse_train_gen_phase_timer #(
    .TIMER_W (TIMER_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (w_tmr_load),
    .load_value (w_tmr_load_value),
    .zero       (w_tmr_zero)
  );

  always_comb begin
    state_d          = state_q;
    pulse_out_d      = 1'b0;
    busy_d           = 1'b0;
    done_d           = 1'b0;
    remaining_d      = remaining_q;
    w_tmr_load       = 1'b0;
    w_tmr_load_value = C_HIGH_LOAD;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count_in != '0) begin
            state_d     = ST_HIGH;
            pulse_out_d = 1'b1;
            busy_d      = 1'b1;
            remaining_d = count_in;
            w_tmr_load  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_HIGH: begin
        if (abort) begin
          state_d          = ST_IDLE;
          remaining_d      = '0;
          w_tmr_load       = 1'b1;
          w_tmr_load_value = '0;
        end else if (w_tmr_zero) begin
          state_d          = ST_LOW;
          busy_d           = 1'b1;
          w_tmr_load       = 1'b1;
          w_tmr_load_value = C_LOW_LOAD;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - CNT_W'(1);
          end
        end else begin
          pulse_out_d = 1'b1;
          busy_d      = 1'b1;
        end
      end

      ST_LOW: begin
        if (abort) begin
          state_d          = ST_IDLE;
          remaining_d      = '0;
          w_tmr_load       = 1'b1;
          w_tmr_load_value = '0;
        end else if (w_tmr_zero) begin
          // The trailing low phase of the last pulse is complete here too.
          if (remaining_q != '0) begin
            state_d     = ST_HIGH;
            pulse_out_d = 1'b1;
            busy_d      = 1'b1;
            w_tmr_load  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      pulse_out_q <= pulse_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      remaining_q <= remaining_d;
    end
  end

  assign pulse_out = pulse_out_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign remaining = remaining_q;

endmodule
`default_nettype wire
